// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types and width helpers for the forwarding scoreboard.
//   entry_t  : one in-flight register write {valid, we, dst, rdy}
//   SEL_RF   : fwd_sel code meaning "read the register file"
//   sel_w()  : width of a per-source select (0 = RF, j+1 = stage j)
//   rdy_w()  : width of a ready-stage index
// entry_t fields are sized to fixed maxima so one struct serves every
// instance; ADDR_W must not exceed ADDR_W_MAX and clog2(DEPTH) must not
// exceed RDY_W_MAX.
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int ADDR_W_MAX = 8;
  localparam int RDY_W_MAX  = 4;
  localparam int SEL_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_W_MAX-1:0] dst;
    logic [RDY_W_MAX-1:0]  rdy;
  } entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single tracked stage still needs a 1-bit port.
  function automatic int rdy_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Priority matcher for one source operand over the DEPTH scoreboard entries.
// The lowest matching index (youngest producer) wins.
// Ports:
//   ent_i       in   scoreboard entries, index 0 = EX
//   src_addr_i  in   source register address
//   src_used_i  in   source is actually read
//   sel_o       out  0 = register file, j+1 = stage j result bus
//   stall_req_o out  winning producer's value is not on its bus yet
// -----------------------------------------------------------------------------
module fwd_match
  import fwd_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = sel_w(DEPTH)
) (
  input  entry_t            ent_i [DEPTH],
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic              src_used_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              stall_req_o
);

  logic [ADDR_W_MAX-1:0] src_ext;
  logic [DEPTH-1:0]      hit;
  logic [DEPTH-1:0]      late;

  assign src_ext = ADDR_W_MAX'(src_addr_i);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    // dst != 0 keeps $0 from ever matching (and so from ever stalling).
    assign hit[gi]  = ent_i[gi].valid & ent_i[gi].we & src_used_i &
                      (ent_i[gi].dst != '0) & (ent_i[gi].dst == src_ext);
    // Value first appears on stage rdy's bus; at an earlier stage it is late.
    assign late[gi] = (ent_i[gi].rdy > RDY_W_MAX'(gi));
  end

  // Walk oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    sel_o       = SEL_W'(SEL_RF);
    stall_req_o = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (hit[j]) begin
        sel_o       = SEL_W'(j + 1);
        stall_req_o = late[j];
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
// Forwarding / hazard unit sitting beside the register file in ID. Tracks
// every in-flight register write over DEPTH stages after ID, picks the
// youngest producer for each source, stalls when that producer's data is not
// ready, and counts stalled cycles (saturating).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_src_addr       NUM_SRC packed source addresses (k at [k*ADDR_W +: ADDR_W])
//   id_src_used       per-source read enable
//   id_reg_write      ID instruction writes a register
//   id_dst_addr       destination register
//   id_rdy_stage      first stage whose result bus carries the value
//   flush             kill the ID instruction this cycle
//   stat_clr          clear stall_cnt (wins over a stall)
//   stall             hold PC/IF/ID, bubble into EX
//   fwd_sel           NUM_SRC packed selects, SEL_W bits each
//   stall_cnt         saturating stalled-cycle count
// -----------------------------------------------------------------------------
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int ADDR_W  = 5,
  parameter  int DEPTH   = 3,
  parameter  int CNT_W   = 32,
  localparam int SEL_W   = sel_w(DEPTH),
  localparam int RDY_W   = rdy_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_reg_write,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic [RDY_W-1:0]          id_rdy_stage,
  input  logic                      flush,
  input  logic                      stat_clr,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt
);

  entry_t             ent_q [DEPTH];
  entry_t             push_d;
  logic [NUM_SRC-1:0] src_req;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // ---------------------------------------------------------------------------
  // Per-source matchers
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_match #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_match (
      .ent_i       (ent_q),
      .src_addr_i  (id_src_addr[gi*ADDR_W +: ADDR_W]),
      .src_used_i  (id_src_used[gi]),
      .sel_o       (fwd_sel[gi*SEL_W +: SEL_W]),
      .stall_req_o (src_req[gi])
    );
  end

  // Stall depends only on registered entries and ID inputs, never on itself.
  assign stall = id_valid & ~flush & (|src_req);

  // ---------------------------------------------------------------------------
  // Push mux: a stalled or flushed ID sends a bubble into EX.
  // ---------------------------------------------------------------------------
  always_comb begin
    push_d = '0;
    if (id_valid && !stall && !flush) begin
      push_d.valid = 1'b1;
      push_d.we    = id_reg_write;
      push_d.dst   = ADDR_W_MAX'(id_dst_addr);
      // A ready stage beyond WB is treated as WB.
      push_d.rdy   = (id_rdy_stage > RDY_W'(DEPTH - 1)) ? RDY_W_MAX'(DEPTH - 1)
                                                        : RDY_W_MAX'(id_rdy_stage);
    end
  end

  // ---------------------------------------------------------------------------
  // Entry shift register; entry[DEPTH-1] retires into the write-first RF.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_q[gi] <= '0;
        end else begin
          ent_q[gi] <= push_d;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ent_q[gi] <= '0;
        end else begin
          ent_q[gi] <= ent_q[gi-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating stall counter; clear beats a simultaneous stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forward_scoreboard
// Directed scenarios followed by randomized traffic. A reference model keeps
// the history of issued instructions by cycle number: the producer seen at
// stage j in cycle t is whatever ID pushed in cycle t-1-j. Expected outputs go
// into a queue; a separate monitor pops and compares each cycle.
// -----------------------------------------------------------------------------
module tb_forward_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 3;
  localparam int CNT_W   = 4;
  localparam int SEL_W   = 2;
  localparam int RDY_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      id_valid = 1'b0;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr = '0;
  logic [NUM_SRC-1:0]        id_src_used = '0;
  logic                      id_reg_write = 1'b0;
  logic [ADDR_W-1:0]         id_dst_addr = '0;
  logic [RDY_W-1:0]          id_rdy_stage = '0;
  logic                      flush = 1'b0;
  logic                      stat_clr = 1'b0;
  logic                      stall;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic [CNT_W-1:0]          stall_cnt;

  always #5 clk = ~clk;

  forward_scoreboard #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_addr  (id_src_addr),
    .id_src_used  (id_src_used),
    .id_reg_write (id_reg_write),
    .id_dst_addr  (id_dst_addr),
    .id_rdy_stage (id_rdy_stage),
    .flush        (flush),
    .stat_clr     (stat_clr),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    bit v; int s0; bit u0; int s1; bit u1;
    bit we; int dst; int rdy; bit fl; bit clr;
  } instr_t;

  typedef struct { bit pushed; bit we; int dst; int rdy; } rec_t;

  typedef struct {
    bit                       stall;
    logic [NUM_SRC*SEL_W-1:0] sel;
    int                       cnt;
    int                       t;
  } exp_t;

  rec_t hist [int];
  exp_t exp_q [$];
  int   t = 0;
  int   t_reset = 0;
  int   cnt_model = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input int tc, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, tc, act, req);
    end
  endtask

  function automatic instr_t mk(bit v, int s0, bit u0, int s1, bit u1,
                                bit we, int dst, int rdy, bit fl, bit clr);
    instr_t i;
    i.v = v; i.s0 = s0; i.u0 = u0; i.s1 = s1; i.u1 = u1;
    i.we = we; i.dst = dst; i.rdy = rdy; i.fl = fl; i.clr = clr;
    return i;
  endfunction

  // Reference: youngest earlier write to the source register within DEPTH
  // cycles; its value is late if its ready stage lies beyond its current age.
  function automatic void predict(input instr_t in, output bit st,
                                  output logic [NUM_SRC*SEL_W-1:0] sel);
    int srcs [NUM_SRC];
    bit used [NUM_SRC];
    bit req;
    srcs[0] = in.s0; srcs[1] = in.s1;
    used[0] = in.u0; used[1] = in.u1;
    sel = '0;
    req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int age = 1; age <= DEPTH; age++) begin
        int c;
        c = t - age;
        if (c >= t_reset && hist.exists(c)) begin
          if (hist[c].pushed && hist[c].we && hist[c].dst != 0 &&
              used[k] && hist[c].dst == srcs[k]) begin
            sel[k*SEL_W +: SEL_W] = SEL_W'(age);
            if (hist[c].rdy > age - 1) req = 1'b1;
            break;
          end
        end
      end
    end
    st = in.v && !in.fl && req;
  endfunction

  task automatic drive(input instr_t in);
    id_valid     = in.v;
    id_src_addr  = {ADDR_W'(in.s1), ADDR_W'(in.s0)};
    id_src_used  = {in.u1, in.u0};
    id_reg_write = in.we;
    id_dst_addr  = ADDR_W'(in.dst);
    id_rdy_stage = RDY_W'(in.rdy);
    flush        = in.fl;
    stat_clr     = in.clr;
  endtask

  task automatic cycle(input instr_t in, output bit st);
    exp_t                     e;
    logic [NUM_SRC*SEL_W-1:0] sel;
    rec_t                     r;
    @(negedge clk);
    drive(in);
    predict(in, st, sel);
    e.stall = st; e.sel = sel; e.cnt = cnt_model; e.t = t;
    exp_q.push_back(e);
    @(posedge clk);
    r.pushed = in.v && !st && !in.fl;
    r.we     = in.we;
    r.dst    = in.dst;
    r.rdy    = (in.rdy > DEPTH - 1) ? DEPTH - 1 : in.rdy;
    hist[t]  = r;
    if (in.clr) cnt_model = 0;
    else if (st && cnt_model < CNT_MAX) cnt_model++;
    t++;
  endtask

  task automatic run1(input instr_t in);
    bit st;
    cycle(in, st);
  endtask

  // Re-issue a consumer while it stalls, as the held ID stage would.
  task automatic consume(input instr_t in);
    bit st;
    int n;
    n = 0;
    st = 1'b1;
    while (st && n < 8) begin
      cycle(in, st);
      n++;
    end
    if (st) begin
      n_cmp++; n_fail++;
      $display("FAIL stall_bound cycle=%0d actual=stalled required=released", t);
    end
  endtask

  task automatic reset_mid_stall(input instr_t in);
    exp_t                     e;
    logic [NUM_SRC*SEL_W-1:0] sel;
    bit                       st;
    @(negedge clk);
    drive(in);
    predict(in, st, sel);
    e.stall = st; e.sel = sel; e.cnt = cnt_model; e.t = t;
    exp_q.push_back(e);
    #3;
    check("mid_stall_setup", t, int'(stall), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_stall", t, int'(stall), 0);
    check("rst_async_sel", t, int'(fwd_sel), 0);
    check("rst_async_cnt", t, int'(stall_cnt), 0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    check("post_rst_stall", t, int'(stall), 0);
    hist.delete();
    t = t + 2;
    t_reset = t;
    cnt_model = 0;
  endtask

  // Monitor: compares every queued expectation against DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", e.t, int'(stall), int'(e.stall));
        for (int k = 0; k < NUM_SRC; k++)
          check($sformatf("fwd_sel%0d", k), e.t,
                int'(fwd_sel[k*SEL_W +: SEL_W]), int'(e.sel[k*SEL_W +: SEL_W]));
        check("stall_cnt", e.t, int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", t);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t cur;
    bit     st;
    bit     prev_st;

    // Reset state
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("reset_stall", t, int'(stall), 0);
    check("reset_sel", t, int'(fwd_sel), 0);
    check("reset_cnt", t, int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 1;
    t_reset = 1;

    // ALU then dependent
    run1(mk(1, 1, 1, 2, 1, 1, 3, 0, 0, 0));
    run1(mk(1, 3, 1, 0, 0, 1, 8, 0, 0, 0));
    // Load-use: one stall then forward from stage 1
    run1(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0));
    consume(mk(1, 5, 1, 0, 0, 1, 9, 0, 0, 0));
    // Two writers to $7 at indices 0 and 2, then only index 2, then retired
    run1(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0));
    run1(mk(1, 7, 1, 7, 1, 0, 0, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run1(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run1(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    // $0 writer never matches; unused source never stalls
    run1(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    run1(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    run1(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0));
    run1(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush during load-use
    run1(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0));
    run1(mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0));
    run1(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset mid-stall
    run1(mk(1, 0, 0, 0, 0, 1, 6, 2, 0, 0));
    reset_mid_stall(mk(1, 0, 0, 6, 1, 0, 0, 0, 0, 0));
    run1(mk(1, 6, 1, 6, 1, 0, 0, 0, 0, 0));
    // Counter saturation, then clear during a stall
    for (int i = 0; i < 10; i++) begin
      run1(mk(1, 0, 0, 0, 0, 1, 4, 2, 0, 0));
      consume(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    run1(mk(1, 0, 0, 0, 0, 1, 4, 2, 0, 0));
    run1(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
    consume(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic; a stalled, unflushed instruction is held in ID.
    prev_st = 1'b0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      if (!(prev_st && !cur.fl)) begin
        cur.v   = ($urandom_range(0, 99) < 85);
        cur.s0  = $urandom_range(0, 7);
        cur.s1  = $urandom_range(0, 7);
        cur.u0  = $urandom_range(0, 1);
        cur.u1  = $urandom_range(0, 1);
        cur.we  = ($urandom_range(0, 99) < 70);
        cur.dst = $urandom_range(0, 7);
        cur.rdy = $urandom_range(0, 3);
      end
      cur.fl  = ($urandom_range(0, 99) < 10);
      cur.clr = ($urandom_range(0, 99) < 3);
      cycle(cur, st);
      prev_st = st;
    end

    @(negedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain cycle=%0d actual=%0d required=0", t, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
